// File: rtl/matrix_multiply_engine_v3.sv
// Matrix multiply engine: Z = X*Y (or Z += X*Y) over three internal RAMs,
// with a host port for loading/reading the RAMs while the engine is idle.
module matrix_multiply_engine_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DIM_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DIM_WIDTH-1:0]  x_rows,
    input  logic [DIM_WIDTH-1:0]  y_cols,
    input  logic [DIM_WIDTH-1:0]  x_cols_y_rows,
    input  logic                  acc_mode,
    input  logic [1:0]            ram_sel,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic                  ram_wen,
    input  logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  sat
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned ACC_W  = 2 * DATA_WIDTH + DIM_WIDTH;
    localparam int unsigned IDX_W  = 2 * DIM_WIDTH;
    localparam int unsigned CHK_W  = ((IDX_W > ADDR_WIDTH) ? IDX_W : ADDR_WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, CHECK, ZRD, MAC, DRAIN, WR, FIN} state_t;

    state_t state, next_state;

    logic [DATA_WIDTH-1:0] x_mem [DEPTH];
    logic [DATA_WIDTH-1:0] y_mem [DEPTH];
    logic [DATA_WIDTH-1:0] z_mem [DEPTH];
    logic [DATA_WIDTH-1:0] x_rd, y_rd, z_rd;

    logic [DIM_WIDTH-1:0] m_q, n_q, k_q;
    logic                 acc_mode_q;
    logic [DIM_WIDTH-1:0] i_q, j_q, k_cnt;
    logic [ACC_W-1:0]     acc;
    logic                 p_valid;

    logic                  start_c, err_set_c, busy_c, invalid_c;
    logic                  last_k_c, last_j_c, last_i_c;
    logic                  host_we_c, z_we_c, clamp_c;
    logic [ADDR_WIDTH-1:0] x_addr_c, y_addr_c, z_addr_c, z_wa_c;
    logic [DATA_WIDTH-1:0] z_wd_c, clamped_c;
    logic [CHK_W-1:0]      mk_c, kn_c, mn_c, depth_c;
    logic [PROD_W-1:0]     x_ext_c, y_ext_c, prod_c;
    logic [ACC_W-1:0]      prod_ext_c, seed_c;
    logic [ACC_W-DATA_WIDTH:0] acc_hi_c;

    // Dimension validity and loop-end detection from the latched dimensions
    always_comb begin
        mk_c      = CHK_W'(m_q) * CHK_W'(k_q);
        kn_c      = CHK_W'(k_q) * CHK_W'(n_q);
        mn_c      = CHK_W'(m_q) * CHK_W'(n_q);
        depth_c   = CHK_W'(DEPTH);
        invalid_c = (m_q == '0) || (n_q == '0) || (k_q == '0) ||
                    (mk_c > depth_c) || (kn_c > depth_c) || (mn_c > depth_c);
        last_k_c  = (k_cnt == k_q - DIM_WIDTH'(1));
        last_j_c  = (j_q == n_q - DIM_WIDTH'(1));
        last_i_c  = (i_q == m_q - DIM_WIDTH'(1));
    end

    // Row-major engine addresses for X[i][k], Y[k][j] and Z[i][j]
    always_comb begin
        x_addr_c = ADDR_WIDTH'(IDX_W'(i_q) * IDX_W'(k_q) + IDX_W'(k_cnt));
        y_addr_c = ADDR_WIDTH'(IDX_W'(k_cnt) * IDX_W'(n_q) + IDX_W'(j_q));
        z_addr_c = ADDR_WIDTH'(IDX_W'(i_q) * IDX_W'(n_q) + IDX_W'(j_q));
    end

    // Full-precision signed product, accumulator seed and output clamp
    always_comb begin
        x_ext_c    = {{DATA_WIDTH{x_rd[DATA_WIDTH-1]}}, x_rd};
        y_ext_c    = {{DATA_WIDTH{y_rd[DATA_WIDTH-1]}}, y_rd};
        prod_c     = x_ext_c * y_ext_c;
        prod_ext_c = {{DIM_WIDTH{prod_c[PROD_W-1]}}, prod_c};
        seed_c     = acc_mode_q ? {{(ACC_W-DATA_WIDTH){z_rd[DATA_WIDTH-1]}}, z_rd} : '0;
        acc_hi_c   = acc[ACC_W-1:DATA_WIDTH-1];
        clamp_c    = !((&acc_hi_c) || !(|acc_hi_c));
        if (!clamp_c)
            clamped_c = acc[DATA_WIDTH-1:0];
        else if (acc[ACC_W-1])
            clamped_c = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            clamped_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    // Next-state logic; abort overrides every busy state
    always_comb begin
        next_state = state;
        start_c    = 1'b0;
        err_set_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    next_state = CHECK;
                    start_c    = 1'b1;
                end
            end
            CHECK: begin
                if (invalid_c) begin
                    next_state = FIN;
                    err_set_c  = 1'b1;
                end else begin
                    next_state = acc_mode_q ? ZRD : MAC;
                end
            end
            ZRD:   next_state = MAC;
            MAC:   if (last_k_c) next_state = DRAIN;
            DRAIN: next_state = WR;
            WR: begin
                if (last_i_c && last_j_c) next_state = FIN;
                else                      next_state = acc_mode_q ? ZRD : MAC;
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort && (state != IDLE) && (state != FIN)) begin
            next_state = IDLE;
            err_set_c  = 1'b0;
        end
        busy_c = (next_state != IDLE) && (next_state != FIN);
    end

    // RAM write enables and Z write mux (engine owns Z in WR)
    always_comb begin
        host_we_c = ram_wen && !busy;
        z_we_c    = (state == WR) || (host_we_c && (ram_sel == 2'b10));
        z_wa_c    = (state == WR) ? z_addr_c  : ram_addr;
        z_wd_c    = (state == WR) ? clamped_c : ram_data_in;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            sat  <= 1'b0;
        end else begin
            busy <= busy_c;
            done <= (next_state == FIN);
            if (start_c)        err <= 1'b0;
            else if (err_set_c) err <= 1'b1;
            if (start_c)                        sat <= 1'b0;
            else if ((state == WR) && clamp_c)  sat <= 1'b1;
        end
    end

    // Dimension latch, loop counters and accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q        <= '0;
            n_q        <= '0;
            k_q        <= '0;
            acc_mode_q <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            k_cnt      <= '0;
            acc        <= '0;
            p_valid    <= 1'b0;
        end else begin
            p_valid <= (state == MAC);
            if (start_c) begin
                m_q        <= x_rows;
                n_q        <= y_cols;
                k_q        <= x_cols_y_rows;
                acc_mode_q <= acc_mode;
            end
            case (state)
                CHECK: begin
                    i_q   <= '0;
                    j_q   <= '0;
                    k_cnt <= '0;
                end
                MAC: k_cnt <= last_k_c ? '0 : k_cnt + DIM_WIDTH'(1);
                WR: begin
                    if (last_j_c) begin
                        j_q <= '0;
                        i_q <= i_q + DIM_WIDTH'(1);
                    end else begin
                        j_q <= j_q + DIM_WIDTH'(1);
                    end
                end
                default: ;
            endcase
            // First MAC cycle has no product pending, so it loads the seed instead
            if ((state == MAC) && (k_cnt == '0)) acc <= seed_c;
            else if (p_valid)                    acc <= acc + prod_ext_c;
        end
    end

    // RAM arrays: synchronous write, registered engine-side read
    always_ff @(posedge clk) begin
        if (host_we_c && (ram_sel == 2'b00)) x_mem[ram_addr] <= ram_data_in;
        if (host_we_c && (ram_sel == 2'b01)) y_mem[ram_addr] <= ram_data_in;
        if (z_we_c)                          z_mem[z_wa_c]   <= z_wd_c;
        x_rd <= x_mem[x_addr_c];
        y_rd <= y_mem[y_addr_c];
        z_rd <= z_mem[z_addr_c];
    end

    // Host-side registered read; forced to zero whenever the engine is busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_data_out <= '0;
        end else if (busy_c) begin
            ram_data_out <= '0;
        end else begin
            case (ram_sel)
                2'b00:   ram_data_out <= x_mem[ram_addr];
                2'b01:   ram_data_out <= y_mem[ram_addr];
                2'b10:   ram_data_out <= z_mem[ram_addr];
                default: ram_data_out <= '0;
            endcase
        end
    end

endmodule
